sync_porch: RTL
===============

Name: sync_porch

Overview:
- Downstream of the row/column sync-counter stage, directly upstream of the VGA pins.
- Takes active-region sync flags and a pixel stream, and owns a frame-aligned column/row counter pair.
- Regenerates standard negative-polarity hsync/vsync pulses with front/back porch placement.
- Forces the RGB outputs to zero outside the active area, so the panel sees clean blanking.

Parameters:
- TOTAL_COLS, 800, total pixel clocks per line
- TOTAL_ROWS, 525, total lines per frame
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- FRONT_PORCH_H, 16, pixel clocks between end of active and start of hsync pulse
- SYNC_WIDTH_H, 96, hsync pulse width in pixel clocks
- FRONT_PORCH_V, 10, lines between end of active and start of vsync pulse
- SYNC_WIDTH_V, 2, vsync pulse width in lines
- VIDEO_WIDTH, 3, bits per colour channel

Ports:
- clk  input  1  pixel clock; sole clock. Single clock; reset is synchronous and active-high.
- i_rst  input  1  synchronous active-high reset
- i_hsync  input  1  high during active columns of a line (upstream active-region flag)
- i_vsync  input  1  high during active rows of a frame (upstream active-region flag)
- i_red  input  VIDEO_WIDTH  pixel red, aligned with i_hsync/i_vsync
- i_grn  input  VIDEO_WIDTH  pixel green
- i_blu  input  VIDEO_WIDTH  pixel blue
- o_hsync  output  1  VGA hsync, active low
- o_vsync  output  1  VGA vsync, active low
- o_red  output  VIDEO_WIDTH  blanked red
- o_grn  output  VIDEO_WIDTH  blanked green
- o_blu  output  VIDEO_WIDTH  blanked blue
- o_locked  output  1  high once a frame start has been seen

Behaviour:
- Reset (i_rst=1 at a clk edge) overrides everything that cycle. Values after reset:
  - o_hsync=1, o_vsync=1
  - o_red/o_grn/o_blu=0
  - o_locked=0
  - internal col/row counters=0, stage-1 registers=0, previous-vsync register=0
- Pipeline: two register stages; every output lags its input by exactly 2 clocks.
- Stage 1, every cycle:
  - Register video inputs and i_vsync; keep prev_vsync.
  - Frame start = i_vsync=1 and prev_vsync=0 (rising edge).
  - On frame start: col<=0, row<=0, lock flag<=1.
  - Otherwise: col increments. If col==TOTAL_COLS-1 then col<=0, and row increments, wrapping TOTAL_ROWS-1 -> 0.
  - Otherwise row holds.
  - Counters are 10 bits; the counter value in stage 1 is aligned with the stage-1 video register.
- Stage 2, from stage-1 col/row:
  - o_hsync=0 iff ACTIVE_COLS+FRONT_PORCH_H <= col < ACTIVE_COLS+FRONT_PORCH_H+SYNC_WIDTH_H; else 1.
  - o_vsync=0 iff ACTIVE_ROWS+FRONT_PORCH_V <= row < ACTIVE_ROWS+FRONT_PORCH_V+SYNC_WIDTH_V; else 1.
  - Video passes iff col<ACTIVE_COLS and row<ACTIVE_ROWS; else 0.
  - o_locked = stage-1 lock flag.
- Unlocked state (o_locked=0): o_hsync=1, o_vsync=1, video=0, regardless of counters.
- Re-alignment: a frame start arriving mid-frame forces col/row to 0 on that edge, with no glitch suppression.
  - An in-progress sync pulse truncates 2 clocks later.
  - Lock stays high.
- i_hsync is registered only for alignment checking and does not drive counters.
- i_vsync held high continuously produces exactly one frame start.
- Reset mid-frame clears lock; outputs stay blanked/inactive until the next i_vsync rising edge is registered through both stages.

Test Plan:
- Reset, then i_vsync rises at cycle T:
  - Stage-1 col=0,row=0 at T+1.
  - o_locked=1 at T+2.
  - Pixel (R,G,B)=(7,5,3) presented at T appears on outputs at T+2.
- Free-run one line after lock:
  - o_hsync low for exactly 96 clocks, first low at output col 656, last at 751.
  - RGB zero for output cols 640..799.
- Free-run full frame:
  - o_vsync low only on rows 490 and 491, for 1600 clocks total.
  - Row wraps 524->0 and col wraps 799->0 on the same edge.
- i_vsync held high 500 cycles, then low, then high again:
  - Counters reset only at the two rising edges.
  - No re-zero while held.
- Assert i_rst at row 200, col 300 during valid video:
  - Within 1 clock, o_locked=0, o_hsync=o_vsync=1, RGB=0.
  - Remain so until 2 clocks after the next i_vsync rise.
- Mid-frame i_vsync rise while output col=700 (inside hsync pulse):
  - o_hsync returns high 2 clocks later.
  - Counters restart at 0.
  - Lock stays 1.

Source files
------------

// File: rtl/sync_porch.sv
// VGA output stage: frame-aligned col/row counters regenerate negative-polarity
// hsync/vsync with porch placement and blank the RGB outside the active area.
module sync_porch #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int FRONT_PORCH_H = 16,
    parameter int SYNC_WIDTH_H  = 96,
    parameter int FRONT_PORCH_V = 10,
    parameter int SYNC_WIDTH_V  = 2,
    parameter int VIDEO_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic [VIDEO_WIDTH-1:0] i_red,
    input  logic [VIDEO_WIDTH-1:0] i_grn,
    input  logic [VIDEO_WIDTH-1:0] i_blu,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic [VIDEO_WIDTH-1:0] o_red,
    output logic [VIDEO_WIDTH-1:0] o_grn,
    output logic [VIDEO_WIDTH-1:0] o_blu,
    output logic                   o_locked
);

    localparam int CW = 10;
    localparam logic [CW-1:0] LAST_COL     = CW'(TOTAL_COLS - 1);
    localparam logic [CW-1:0] LAST_ROW     = CW'(TOTAL_ROWS - 1);
    localparam logic [CW-1:0] ACT_COLS     = CW'(ACTIVE_COLS);
    localparam logic [CW-1:0] ACT_ROWS     = CW'(ACTIVE_ROWS);
    localparam logic [CW-1:0] H_SYNC_START = CW'(ACTIVE_COLS + FRONT_PORCH_H);
    localparam logic [CW-1:0] H_SYNC_END   = CW'(ACTIVE_COLS + FRONT_PORCH_H + SYNC_WIDTH_H);
    localparam logic [CW-1:0] V_SYNC_START = CW'(ACTIVE_ROWS + FRONT_PORCH_V);
    localparam logic [CW-1:0] V_SYNC_END   = CW'(ACTIVE_ROWS + FRONT_PORCH_V + SYNC_WIDTH_V);

    // Stage 1 state: counters are aligned with the registered pixel.
    logic [CW-1:0]          col;
    logic [CW-1:0]          row;
    logic                   s1_lock;
    logic                   prev_vsync;
    logic                   s1_hsync;
    logic [VIDEO_WIDTH-1:0] s1_red;
    logic [VIDEO_WIDTH-1:0] s1_grn;
    logic [VIDEO_WIDTH-1:0] s1_blu;

    logic          frame_start;
    logic [CW-1:0] col_next;
    logic [CW-1:0] row_next;
    logic          h_pulse;
    logic          v_pulse;
    logic          in_active;
    logic          unused_align_err;

    assign frame_start = i_vsync & ~prev_vsync;

    always_comb begin
        col_next = col + 1'b1;
        row_next = row;
        if (frame_start) begin
            col_next = '0;
            row_next = '0;
        end else if (col == LAST_COL) begin
            col_next = '0;
            row_next = (row == LAST_ROW) ? '0 : row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            col        <= '0;
            row        <= '0;
            s1_lock    <= 1'b0;
            prev_vsync <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_red     <= '0;
            s1_grn     <= '0;
            s1_blu     <= '0;
        end else begin
            col        <= col_next;
            row        <= row_next;
            s1_lock    <= s1_lock | frame_start;
            prev_vsync <= i_vsync;
            s1_hsync   <= i_hsync;
            s1_red     <= i_red;
            s1_grn     <= i_grn;
            s1_blu     <= i_blu;
        end
    end

    assign h_pulse   = (col >= H_SYNC_START) && (col < H_SYNC_END);
    assign v_pulse   = (row >= V_SYNC_START) && (row < V_SYNC_END);
    assign in_active = (col < ACT_COLS) && (row < ACT_ROWS);

    // Upstream active-column flag disagreeing with our own column count; kept
    // as an observation point only, it never steers the counters.
    assign unused_align_err = s1_lock & (s1_hsync ^ (col < ACT_COLS));

    always_ff @(posedge clk) begin
        if (i_rst || !s1_lock) begin
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
            o_red   <= '0;
            o_grn   <= '0;
            o_blu   <= '0;
        end else begin
            o_hsync <= ~h_pulse;
            o_vsync <= ~v_pulse;
            o_red   <= in_active ? s1_red : '0;
            o_grn   <= in_active ? s1_grn : '0;
            o_blu   <= in_active ? s1_blu : '0;
        end
        o_locked <= i_rst ? 1'b0 : s1_lock;
    end

endmodule
